// File: rtl/multicycle_sequencer_if.sv
// Bundle between the multi-cycle sequencer and its surroundings:
// the instruction register, the shared memory port and the datapath mux/strobe controls.
`timescale 1ns/1ps

interface multicycle_sequencer_if #(
    parameter int unsigned WORD             = 32,
    parameter int unsigned REG_SIZE         = 5,
    parameter int unsigned ALU_CONTROL_SIZE = 4
);
    logic [WORD-1:0]             instr;
    logic                        mem_ready;
    logic                        mem_req;
    logic                        mem_we;
    logic                        mem_addr_sel;
    logic                        ir_write;
    logic                        pc_write;
    logic                        reg_write;
    logic [REG_SIZE-1:0]         rs1;
    logic [REG_SIZE-1:0]         rs2;
    logic [REG_SIZE-1:0]         rd;
    logic [ALU_CONTROL_SIZE-1:0] alu_control;
    logic                        alu_src_imm;
    logic [1:0]                  imm_sel;
    logic [1:0]                  wb_sel;
    logic                        instr_done;
    logic                        halted;
    logic                        illegal;

    // Sequencer side: drives the memory request and every datapath control
    modport master (
        input  instr, mem_ready,
        output mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write,
               rs1, rs2, rd, alu_control, alu_src_imm, imm_sel, wb_sel,
               instr_done, halted, illegal
    );

    // Environment side: instruction register and memory port
    modport slave (
        output instr, mem_ready,
        input  mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write,
               rs1, rs2, rd, alu_control, alu_src_imm, imm_sel, wb_sel,
               instr_done, halted, illegal
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the RV32I-subset core (LOAD, STORE, ADDI, ADD, LUI, ECALL).
// Sequences FETCH -> DECODE -> EXEC -> [MEM] -> WB over one shared memory port, halts on
// ECALL and traps on illegal encodings or a memory request that is not answered in time.
// Level outputs are registered from the next state; ir_write, pc_write and instr_done are
// registered enables gated by mem_ready so a transfer completes in the cycle it is acknowledged.
`timescale 1ns/1ps

module multicycle_sequencer #(
    parameter int unsigned TIMEOUT          = 16,
    parameter int unsigned WORD             = 32,
    parameter int unsigned REG_SIZE         = 5,
    parameter int unsigned ALU_CONTROL_SIZE = 4,
    parameter logic [ALU_CONTROL_SIZE-1:0] ALU_ADD = {ALU_CONTROL_SIZE{1'b0}}
) (
    input logic                    clk,
    input logic                    rst_n,
    multicycle_sequencer_if.master bus
);

    // A zero TIMEOUT disables the watchdog; keep the counter at least one bit wide
    localparam int unsigned  CNT_W      = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned  LIMIT_I    = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = LIMIT_I[CNT_W-1:0];
    localparam logic         TIMEOUT_EN = (TIMEOUT != 0);

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_U = 2'b10;
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_UIM = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_TRAP   = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_ADDI    = 3'd3,
        CLS_ADD     = 3'd4,
        CLS_LUI     = 3'd5,
        CLS_ECALL   = 3'd6
    } cls_e;

    // Registered control bundle; the *_en fields are gated by mem_ready at the outputs
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       reg_write;
        logic       alu_src_imm;
        logic [1:0] imm_sel;
        logic [1:0] wb_sel;
        logic       halted;
        logic       illegal;
        logic       ir_en;
        logic       store_done_en;
        logic       wb_done;
    } outs_t;

    // Classify the instruction register contents
    function automatic cls_e decode_class(input logic [31:0] ins);
        cls_e c;
        c = CLS_ILLEGAL;
        case (ins[6:0])
            7'b0000011: c = CLS_LOAD;
            7'b0100011: c = CLS_STORE;
            7'b0010011: begin
                if (ins[14:12] == 3'b000) c = CLS_ADDI;
                else                      c = CLS_ILLEGAL;
            end
            7'b0110011: begin
                if ((ins[14:12] == 3'b000) && (ins[31:25] == 7'b0000000)) c = CLS_ADD;
                else                                                        c = CLS_ILLEGAL;
            end
            7'b0110111: c = CLS_LUI;
            7'b1110011: begin
                if (ins[31:7] == 25'd0) c = CLS_ECALL;
                else                    c = CLS_ILLEGAL;
            end
            default:    c = CLS_ILLEGAL;
        endcase
        return c;
    endfunction

    // Immediate format selected for a class
    function automatic logic [1:0] imm_for(input cls_e cls);
        logic [1:0] s;
        case (cls)
            CLS_STORE: s = IMM_S;
            CLS_LUI:   s = IMM_U;
            default:   s = IMM_I;
        endcase
        return s;
    endfunction

    // Writeback source selected for a class
    function automatic logic [1:0] wb_for(input cls_e cls);
        logic [1:0] s;
        case (cls)
            CLS_LOAD: s = WB_MEM;
            CLS_LUI:  s = WB_UIM;
            default:  s = WB_ALU;
        endcase
        return s;
    endfunction

    // Moore decode of the controls for a given state and instruction class
    function automatic outs_t moore_outs(input state_e st, input cls_e cls);
        outs_t o;
        logic  imm_op;
        o      = '0;
        imm_op = (cls == CLS_LOAD) || (cls == CLS_STORE) || (cls == CLS_ADDI);
        case (st)
            ST_FETCH: begin
                o.mem_req = 1'b1;
                o.ir_en   = 1'b1;
            end
            ST_EXEC: begin
                o.alu_src_imm = imm_op;
                o.imm_sel     = imm_for(cls);
            end
            ST_MEM: begin
                // Immediate controls held so the ALU address stays stable
                o.mem_req       = 1'b1;
                o.mem_addr_sel  = 1'b1;
                o.mem_we        = (cls == CLS_STORE);
                o.alu_src_imm   = imm_op;
                o.imm_sel       = imm_for(cls);
                o.store_done_en = (cls == CLS_STORE);
            end
            ST_WB: begin
                // rd == x0 still writes; the register file discards it
                o.reg_write   = 1'b1;
                o.wb_done     = 1'b1;
                o.alu_src_imm = imm_op;
                o.imm_sel     = imm_for(cls);
                o.wb_sel      = wb_for(cls);
            end
            ST_HALT:  o.halted  = 1'b1;
            ST_TRAP:  o.illegal = 1'b1;
            default:  o = '0;
        endcase
        return o;
    endfunction

    state_e           r_state;
    cls_e             r_class;
    logic [CNT_W-1:0] r_cnt;
    logic             r_run;
    outs_t            r_outs;

    state_e           w_state_nxt;
    cls_e             w_class;
    cls_e             w_class_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_timeout;
    logic             w_in_xfer;
    logic [31:0]      w_instr;

    assign w_instr = bus.instr[31:0];
    assign w_class = decode_class(w_instr);

    // Request is outstanding in FETCH and MEM only; mem_ready is ignored elsewhere
    assign w_in_xfer = (r_state == ST_FETCH) || (r_state == ST_MEM);
    // Watchdog fires on the last allowed wait cycle unless memory answers in that same cycle
    assign w_timeout = TIMEOUT_EN && w_in_xfer && (r_cnt == CNT_LIMIT) && !bus.mem_ready;

    // Next-state selection
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                // r_run delays leaving IDLE until one full cycle after reset release
                if (r_run) w_state_nxt = ST_FETCH;
                else       w_state_nxt = ST_IDLE;
            end
            ST_FETCH: begin
                if (bus.mem_ready)  w_state_nxt = ST_DECODE;
                else if (w_timeout) w_state_nxt = ST_TRAP;
                else                w_state_nxt = ST_FETCH;
            end
            ST_DECODE: begin
                case (w_class)
                    CLS_ECALL:   w_state_nxt = ST_HALT;
                    CLS_ILLEGAL: w_state_nxt = ST_TRAP;
                    default:     w_state_nxt = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (r_class)
                    CLS_LOAD, CLS_STORE:         w_state_nxt = ST_MEM;
                    CLS_ADDI, CLS_ADD, CLS_LUI:  w_state_nxt = ST_WB;
                    default:                     w_state_nxt = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                if (bus.mem_ready) begin
                    if (r_class == CLS_STORE) w_state_nxt = ST_FETCH;
                    else                      w_state_nxt = ST_WB;
                end else if (w_timeout) begin
                    w_state_nxt = ST_TRAP;
                end else begin
                    w_state_nxt = ST_MEM;
                end
            end
            ST_WB:   w_state_nxt = ST_FETCH;
            ST_HALT: w_state_nxt = ST_HALT;
            ST_TRAP: w_state_nxt = ST_TRAP;
            default: w_state_nxt = ST_TRAP;
        endcase
    end

    // Class is captured when leaving DECODE and held through WB
    always_comb begin
        if (r_state == ST_DECODE) w_class_nxt = w_class;
        else                      w_class_nxt = r_class;
    end

    // Wait counter: cleared on entry to a request state, counts unanswered request cycles
    always_comb begin
        w_cnt_nxt = r_cnt;
        if ((w_state_nxt != r_state) &&
            ((w_state_nxt == ST_FETCH) || (w_state_nxt == ST_MEM))) begin
            w_cnt_nxt = {CNT_W{1'b0}};
        end else if (w_in_xfer && !bus.mem_ready) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Sequencer state, class, wait counter and registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_class <= CLS_ILLEGAL;
            r_cnt   <= {CNT_W{1'b0}};
            r_run   <= 1'b0;
            r_outs  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_class <= w_class_nxt;
            r_cnt   <= w_cnt_nxt;
            r_run   <= 1'b1;
            r_outs  <= moore_outs(w_state_nxt, w_class_nxt);
        end
    end

    assign bus.mem_req      = r_outs.mem_req;
    assign bus.mem_we       = r_outs.mem_we;
    assign bus.mem_addr_sel = r_outs.mem_addr_sel;
    assign bus.reg_write    = r_outs.reg_write;
    assign bus.alu_src_imm  = r_outs.alu_src_imm;
    assign bus.imm_sel      = r_outs.imm_sel;
    assign bus.wb_sel       = r_outs.wb_sel;
    assign bus.halted       = r_outs.halted;
    assign bus.illegal      = r_outs.illegal;
    assign bus.ir_write     = r_outs.ir_en & bus.mem_ready;
    assign bus.pc_write     = r_outs.wb_done | (r_outs.store_done_en & bus.mem_ready);
    assign bus.instr_done   = r_outs.wb_done | (r_outs.store_done_en & bus.mem_ready);
    assign bus.alu_control  = ALU_ADD;
    assign bus.rs1          = w_instr[19:15];
    assign bus.rs2          = w_instr[24:20];
    assign bus.rd           = w_instr[11:7];

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer (TIMEOUT = 4): ADDI, LW with a 3-cycle MEM wait
// that lands exactly on the watchdog limit, SW, LUI, ADD, async reset mid-MEM, SUB trap,
// FETCH timeout trap and ECALL halt.
`timescale 1ns/1ps

module tb_multicycle_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    multicycle_sequencer_if bus_if ();

    multicycle_sequencer #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".mem_req"},      {31'd0, bus_if.mem_req},      32'd0);
        chk({tag, ".mem_we"},       {31'd0, bus_if.mem_we},       32'd0);
        chk({tag, ".mem_addr_sel"}, {31'd0, bus_if.mem_addr_sel}, 32'd0);
        chk({tag, ".ir_write"},     {31'd0, bus_if.ir_write},     32'd0);
        chk({tag, ".pc_write"},     {31'd0, bus_if.pc_write},     32'd0);
        chk({tag, ".reg_write"},    {31'd0, bus_if.reg_write},    32'd0);
        chk({tag, ".alu_src_imm"},  {31'd0, bus_if.alu_src_imm},  32'd0);
        chk({tag, ".imm_sel"},      {30'd0, bus_if.imm_sel},      32'd0);
        chk({tag, ".wb_sel"},       {30'd0, bus_if.wb_sel},       32'd0);
        chk({tag, ".instr_done"},   {31'd0, bus_if.instr_done},   32'd0);
        chk({tag, ".halted"},       {31'd0, bus_if.halted},       32'd0);
        chk({tag, ".illegal"},      {31'd0, bus_if.illegal},      32'd0);
    endtask

    // Reset, release at a falling edge, then step to the first FETCH
    task automatic restart();
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        rst_n            = 1'b0;
        bus_if.instr     = 32'h00500093;
        bus_if.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");
        chk("reset.alu_control", {28'd0, bus_if.alu_control}, 32'd0);
        chk("reset.rs1", {27'd0, bus_if.rs1}, 32'd0);
        chk("reset.rs2", {27'd0, bus_if.rs2}, 32'd5);
        chk("reset.rd",  {27'd0, bus_if.rd},  32'd1);

        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_cycle.mem_req", {31'd0, bus_if.mem_req}, 32'd0);
        tick();
        chk("first_fetch.mem_req", {31'd0, bus_if.mem_req}, 32'd1);

        // ADDI x1, x0, 5 with zero-wait memory
        bus_if.mem_ready = 1'b1;
        #1;
        chk("addi.fetch.ir_write", {31'd0, bus_if.ir_write},     32'd1);
        chk("addi.fetch.addr_sel", {31'd0, bus_if.mem_addr_sel}, 32'd0);
        chk("addi.fetch.we",       {31'd0, bus_if.mem_we},       32'd0);
        tick();
        chk("addi.decode.mem_req",  {31'd0, bus_if.mem_req},  32'd0);
        chk("addi.decode.ir_write", {31'd0, bus_if.ir_write}, 32'd0);
        tick();
        chk("addi.exec.alu_src_imm", {31'd0, bus_if.alu_src_imm}, 32'd1);
        chk("addi.exec.imm_sel",     {30'd0, bus_if.imm_sel},     32'd0);
        chk("addi.exec.reg_write",   {31'd0, bus_if.reg_write},   32'd0);
        tick();
        chk("addi.wb.reg_write",   {31'd0, bus_if.reg_write},   32'd1);
        chk("addi.wb.wb_sel",      {30'd0, bus_if.wb_sel},      32'd0);
        chk("addi.wb.alu_src_imm", {31'd0, bus_if.alu_src_imm}, 32'd1);
        chk("addi.wb.rd",          {27'd0, bus_if.rd},          32'd1);
        chk("addi.wb.instr_done",  {31'd0, bus_if.instr_done},  32'd1);
        chk("addi.wb.pc_write",    {31'd0, bus_if.pc_write},    32'd1);
        tick();
        chk("addi.next.instr_done", {31'd0, bus_if.instr_done}, 32'd0);
        chk("addi.next.mem_req",    {31'd0, bus_if.mem_req},    32'd1);

        // LW x2, 4(x1): MEM waits 3 cycles, ready arrives on the watchdog's last cycle
        bus_if.instr = 32'h0040A103;
        #1;
        chk("lw.fetch.ir_write", {31'd0, bus_if.ir_write}, 32'd1);
        tick();
        tick();
        bus_if.mem_ready = 1'b0;
        #1;
        chk("lw.exec.alu_src_imm", {31'd0, bus_if.alu_src_imm}, 32'd1);
        chk("lw.exec.mem_req",     {31'd0, bus_if.mem_req},     32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lw.mem_wait.mem_req",  {31'd0, bus_if.mem_req},      32'd1);
            chk("lw.mem_wait.addr_sel", {31'd0, bus_if.mem_addr_sel}, 32'd1);
            chk("lw.mem_wait.we",       {31'd0, bus_if.mem_we},       32'd0);
            chk("lw.mem_wait.illegal",  {31'd0, bus_if.illegal},      32'd0);
        end
        tick();
        bus_if.mem_ready = 1'b1;
        #1;
        chk("lw.mem_ready.addr_sel", {31'd0, bus_if.mem_addr_sel}, 32'd1);
        chk("lw.mem_ready.pc_write", {31'd0, bus_if.pc_write},     32'd0);
        tick();
        chk("lw.wb.illegal",    {31'd0, bus_if.illegal},    32'd0);
        chk("lw.wb.wb_sel",     {30'd0, bus_if.wb_sel},     32'd1);
        chk("lw.wb.reg_write",  {31'd0, bus_if.reg_write},  32'd1);
        chk("lw.wb.instr_done", {31'd0, bus_if.instr_done}, 32'd1);
        tick();
        chk("lw.next.mem_req", {31'd0, bus_if.mem_req}, 32'd1);

        // SW x2, 8(x1)
        bus_if.instr = 32'h0020A423;
        #1;
        chk("sw.fetch.ir_write", {31'd0, bus_if.ir_write}, 32'd1);
        tick();
        tick();
        chk("sw.exec.imm_sel", {30'd0, bus_if.imm_sel}, 32'd1);
        chk("sw.exec.mem_we",  {31'd0, bus_if.mem_we},  32'd0);
        tick();
        chk("sw.mem.mem_we",     {31'd0, bus_if.mem_we},       32'd1);
        chk("sw.mem.imm_sel",    {30'd0, bus_if.imm_sel},      32'd1);
        chk("sw.mem.addr_sel",   {31'd0, bus_if.mem_addr_sel}, 32'd1);
        chk("sw.mem.pc_write",   {31'd0, bus_if.pc_write},     32'd1);
        chk("sw.mem.instr_done", {31'd0, bus_if.instr_done},   32'd1);
        chk("sw.mem.reg_write",  {31'd0, bus_if.reg_write},    32'd0);
        tick();
        chk("sw.next.mem_req",    {31'd0, bus_if.mem_req},    32'd1);
        chk("sw.next.reg_write",  {31'd0, bus_if.reg_write},  32'd0);
        chk("sw.next.instr_done", {31'd0, bus_if.instr_done}, 32'd0);

        // LUI x3, 0x12345
        bus_if.instr = 32'h123451B7;
        tick();
        tick();
        chk("lui.exec.imm_sel",     {30'd0, bus_if.imm_sel},     32'd2);
        chk("lui.exec.alu_src_imm", {31'd0, bus_if.alu_src_imm}, 32'd0);
        tick();
        chk("lui.wb.wb_sel",    {30'd0, bus_if.wb_sel},    32'd2);
        chk("lui.wb.reg_write", {31'd0, bus_if.reg_write}, 32'd1);
        chk("lui.wb.rd",        {27'd0, bus_if.rd},        32'd3);
        tick();

        // ADD x3, x1, x2
        bus_if.instr = 32'h002081B3;
        #1;
        chk("add.rs1", {27'd0, bus_if.rs1}, 32'd1);
        chk("add.rs2", {27'd0, bus_if.rs2}, 32'd2);
        tick();
        tick();
        chk("add.exec.alu_src_imm", {31'd0, bus_if.alu_src_imm}, 32'd0);
        tick();
        chk("add.wb.wb_sel",     {30'd0, bus_if.wb_sel},     32'd0);
        chk("add.wb.instr_done", {31'd0, bus_if.instr_done}, 32'd1);
        tick();

        // Async reset in the middle of a LOAD's MEM wait
        bus_if.instr = 32'h0040A103;
        tick();
        tick();
        bus_if.mem_ready = 1'b0;
        tick();
        chk("rst_mid.mem.mem_req", {31'd0, bus_if.mem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid.async.mem_req",  {31'd0, bus_if.mem_req},      32'd0);
        chk("rst_mid.async.addr_sel", {31'd0, bus_if.mem_addr_sel}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_mid.idle.mem_req", {31'd0, bus_if.mem_req}, 32'd0);
        tick();
        chk("rst_mid.fetch.mem_req", {31'd0, bus_if.mem_req}, 32'd1);

        // SUB is not in the subset: trap after DECODE
        bus_if.instr     = 32'h40000033;
        bus_if.mem_ready = 1'b1;
        tick();
        tick();
        chk("sub.trap.illegal", {31'd0, bus_if.illegal}, 32'd1);
        chk("sub.trap.mem_req", {31'd0, bus_if.mem_req}, 32'd0);
        chk("sub.trap.halted",  {31'd0, bus_if.halted},  32'd0);
        tick();
        tick();
        chk("sub.sticky.illegal",  {31'd0, bus_if.illegal},  32'd1);
        chk("sub.sticky.ir_write", {31'd0, bus_if.ir_write}, 32'd0);

        // FETCH never answered: trap after exactly 4 request cycles
        bus_if.mem_ready = 1'b0;
        restart();
        for (int i = 0; i < 4; i++) begin
            chk("tmo.wait.mem_req",  {31'd0, bus_if.mem_req},  32'd1);
            chk("tmo.wait.ir_write", {31'd0, bus_if.ir_write}, 32'd0);
            chk("tmo.wait.illegal",  {31'd0, bus_if.illegal},  32'd0);
            tick();
        end
        chk("tmo.trap.illegal", {31'd0, bus_if.illegal}, 32'd1);
        chk("tmo.trap.mem_req", {31'd0, bus_if.mem_req}, 32'd0);

        // ECALL halts; later mem_ready pulses change nothing
        restart();
        bus_if.instr     = 32'h00000073;
        bus_if.mem_ready = 1'b1;
        tick();
        tick();
        chk("ecall.halt.halted",  {31'd0, bus_if.halted},  32'd1);
        chk("ecall.halt.mem_req", {31'd0, bus_if.mem_req}, 32'd0);
        chk("ecall.halt.illegal", {31'd0, bus_if.illegal}, 32'd0);
        bus_if.mem_ready = 1'b0;
        tick();
        bus_if.mem_ready = 1'b1;
        tick();
        chk("ecall.sticky.halted",   {31'd0, bus_if.halted},   32'd1);
        chk("ecall.sticky.mem_req",  {31'd0, bus_if.mem_req},  32'd0);
        chk("ecall.sticky.ir_write", {31'd0, bus_if.ir_write}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("ecall.reset.halted", {31'd0, bus_if.halted}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
